// File: rtl/vote_tally_engine.sv
// -----------------------------------------------------------------------------
// vote_tally_engine
//
// Counts votes for N_CAND candidates. The control unit issues one ballot_arm
// pulse per voter. While armed, exactly one pressed button adds one vote for
// that candidate. A multi-press is rejected and the ballot stays valid once
// all buttons are released. Counters saturate, and sat_flag records that an
// increment was dropped. Counts are read through a registered indexed port.
//
// Ports:
//   clock           system clock, rising edge
//   reset           asynchronous active-high reset, clears all state
//   poll_open       level, high while polling is open
//   ballot_arm      one-cycle pulse authorising one vote
//   cand_vote_valid synchronised candidate buttons (bit i = candidate i)
//   rd_sel          candidate index for readout
//   rd_count        registered count of candidate rd_sel (0 if out of range)
//   total_votes     accepted votes since reset (saturating)
//   armed           high while a ballot is pending
//   vote_accepted   one-cycle pulse after an accepted vote
//   vote_rejected   one-cycle pulse after a multi-press
//   sat_flag        sticky, set when any increment was suppressed
// -----------------------------------------------------------------------------
module vote_tally_engine #(
    parameter int N_CAND = 4,
    parameter int CNT_W  = 8,
    parameter int TOT_W  = 12,
    parameter int SEL_W  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              poll_open,
    input  logic              ballot_arm,
    input  logic [N_CAND-1:0] cand_vote_valid,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_count,
    output logic [TOT_W-1:0]  total_votes,
    output logic              armed,
    output logic              vote_accepted,
    output logic              vote_rejected,
    output logic              sat_flag
);

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        ARMED          = 2'd1,
        WAIT_REL_DONE  = 2'd2,
        WAIT_REL_RETRY = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

    state_t state_reg;
    state_t state_next;

    logic any_press;
    logic one_hot;
    logic accept;
    logic reject;

    logic [N_CAND*CNT_W-1:0] count_flat;
    logic [N_CAND-1:0]       cnt_sat;
    logic                    tot_sat;

    logic [TOT_W-1:0] total_reg;
    logic [CNT_W-1:0] rd_count_reg;
    logic [CNT_W-1:0] rd_count_next;
    logic             accepted_reg;
    logic             rejected_reg;
    logic             sat_flag_reg;

    // Clearing the lowest set bit leaves zero only for a single-bit pattern.
    assign any_press = |cand_vote_valid;
    assign one_hot   = any_press &&
                       ((cand_vote_valid & (cand_vote_valid - N_CAND'(1))) == '0);

    // Closing the poll outranks any press seen in the same cycle.
    assign accept = (state_reg == ARMED) && poll_open && one_hot;
    assign reject = (state_reg == ARMED) && poll_open && any_press && !one_hot;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                // An arm that arrives with a button held or the poll closed is dropped.
                if (ballot_arm && poll_open && !any_press) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (!poll_open) begin
                    state_next = IDLE;
                end else if (one_hot) begin
                    state_next = WAIT_REL_DONE;
                end else if (any_press) begin
                    state_next = WAIT_REL_RETRY;
                end
            end
            WAIT_REL_DONE: begin
                if (!any_press) begin
                    state_next = IDLE;
                end
            end
            WAIT_REL_RETRY: begin
                if (!poll_open) begin
                    state_next = IDLE;
                end else if (!any_press) begin
                    state_next = ARMED;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // armed follows the state directly, so an asynchronous reset drops it at once.
    always_comb begin
        armed = (state_reg == ARMED);
    end

    // ---------------- per-candidate saturating counters ----------------
    genvar gi;
    generate
        for (gi = 0; gi < N_CAND; gi++) begin : gen_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic             hit;

            assign hit         = accept && cand_vote_valid[gi];
            assign cnt_sat[gi] = hit && (cnt_reg == CNT_MAX);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (hit && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign count_flat[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    // ---------------- total, pulses, sticky saturation ----------------
    assign tot_sat = accept && (total_reg == TOT_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            total_reg    <= '0;
            accepted_reg <= 1'b0;
            rejected_reg <= 1'b0;
            sat_flag_reg <= 1'b0;
        end else begin
            if (accept && (total_reg != TOT_MAX)) begin
                total_reg <= total_reg + TOT_W'(1);
            end
            accepted_reg <= accept;
            rejected_reg <= reject;
            sat_flag_reg <= sat_flag_reg | (|cnt_sat) | tot_sat;
        end
    end

    // ---------------- registered readout ----------------
    // Indices past the last candidate read as zero.
    always_comb begin
        rd_count_next = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (int'(rd_sel) == i) begin
                rd_count_next = count_flat[i*CNT_W +: CNT_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_count_reg <= '0;
        end else begin
            rd_count_reg <= rd_count_next;
        end
    end

    assign rd_count      = rd_count_reg;
    assign total_votes   = total_reg;
    assign vote_accepted = accepted_reg;
    assign vote_rejected = rejected_reg;
    assign sat_flag      = sat_flag_reg;

endmodule
